// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter: parallel-in / serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready load port and shifts it out
// one bit per accepted serial handshake, MSB or LSB first. A one-cycle done
// pulse follows the final accepted bit, and a new word may be loaded in that
// same cycle.
module piso_shift_transmitter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done
);

  // The counter only has to reach WIDTH-1, so it never wraps inside a word.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  // The bit at the head of the shift register is always the next one to send.
  logic head_bit;
  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Next-state logic: capture a word in IDLE, consume one bit per handshake in SHIFT.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // load_valid is deliberately not looked at here; words offered while
        // shifting are simply not accepted (load_ready is low).
        if (ser_ready) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          if (cnt_q == LAST_IDX) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset wins over any simultaneous load or acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded from registered state only, so they are glitch-free
  // with respect to the inputs and idle values are forced to zero.
  always_comb begin
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    busy       = 1'b0;
    ser_out    = 1'b0;
    ser_last   = 1'b0;
    if (state_q == SHIFT) begin
      ser_valid = 1'b1;
      busy      = 1'b1;
      ser_out   = head_bit;
      ser_last  = (cnt_q == LAST_IDX);
    end else begin
      load_ready = 1'b1;
    end
  end

  assign done = done_q;

endmodule
